// File: rtl/dram_wbuf_pkg.sv
// Shared definitions for the DRAM posted-write buffer: drain FSM states and
// the default DRAM byte-address width.
package dram_wbuf_pkg;

  localparam int MEM_SCALE_DEF = 27;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_RD_WAIT = 2'd2
  } drain_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write FIFO: power-of-two depth, naturally wrapping pointers and an
// occupancy counter. A push is accepted when full only if a pop happens in
// the same cycle, so the level never exceeds DEPTH or goes below zero.
module wbuf_fifo #(
  parameter  int WIDTH = 63,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign level = count_q;

  // Next pointer and occupancy values from the qualified push/pop.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no latch is inferred on any path.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_x) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // the pre-edge values of the others.
    if (!rst_x) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: storage has no reset; the cleared pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dram_wbuf.sv
// DRAM posted-write buffer between the data cache super port and the DRAM
// arbiter data port. Writes are acknowledged as soon as they enter the FIFO
// (or a single pending slot when it is full); reads wait until every earlier
// write has drained, preserving program order.
module dram_wbuf
  import dram_wbuf_pkg::*;
#(
  parameter  int MEM_SCALE = MEM_SCALE_DEF,
  parameter  int DEPTH     = 4,
  localparam int LW        = $clog2(DEPTH) + 1,
  localparam int EW        = MEM_SCALE + 36
) (
  input  logic                 clk,
  input  logic                 rst_x,
  input  logic                 up_oe,
  input  logic [MEM_SCALE-1:0] up_addr,
  input  logic [31:0]          up_wdata,
  input  logic [3:0]           up_we,
  output logic [31:0]          up_rdata,
  output logic                 up_valid,
  output logic                 up_written,
  output logic                 dn_oe,
  output logic [MEM_SCALE-1:0] dn_addr,
  output logic [31:0]          dn_wdata,
  output logic [3:0]           dn_we,
  input  logic [31:0]          dn_rdata,
  input  logic                 dn_valid,
  input  logic                 dn_written,
  output logic [LW-1:0]        level
);

  drain_state_e         state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 wr_pend_q, wr_pend_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [MEM_SCALE-1:0] req_addr_q, req_addr_d;
  logic [31:0]          req_wdata_q, req_wdata_d;
  logic [3:0]           req_we_q, req_we_d;
  logic                 dn_oe_q, dn_oe_d;
  logic [MEM_SCALE-1:0] dn_addr_q, dn_addr_d;
  logic [31:0]          dn_wdata_q, dn_wdata_d;
  logic [3:0]           dn_we_q, dn_we_d;
  logic                 up_written_q, up_written_d;
  logic                 up_valid_q, up_valid_d;
  logic [31:0]          up_rdata_q, up_rdata_d;

  logic                 accept, is_wr, rd_issue;
  logic                 push, pop, fifo_full, fifo_empty;
  logic [EW-1:0]        push_data, fifo_head;

  wbuf_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_x     (rst_x),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Drain FSM plus upstream acceptance; the FSM part runs first because a
  // full-FIFO write and a read fast path both depend on this cycle's pop/issue.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    wr_pend_d    = wr_pend_q;
    rd_pend_d    = rd_pend_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_we_d     = req_we_q;
    dn_oe_d      = 1'b0;
    dn_addr_d    = dn_addr_q;
    dn_wdata_d   = dn_wdata_q;
    dn_we_d      = dn_we_q;
    up_written_d = 1'b0;
    up_valid_d   = 1'b0;
    up_rdata_d   = up_rdata_q;
    push         = 1'b0;
    pop          = 1'b0;
    push_data    = {up_addr, up_wdata, up_we};
    rd_issue     = 1'b0;
    accept       = up_oe && !busy_q;
    is_wr        = |up_we;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          dn_oe_d                          = 1'b1;
          {dn_addr_d, dn_wdata_d, dn_we_d} = fifo_head;
          state_d                          = ST_WR_WAIT;
        end else if (rd_pend_q || (accept && !is_wr)) begin
          rd_issue   = 1'b1;
          dn_oe_d    = 1'b1;
          dn_addr_d  = rd_pend_q ? req_addr_q : up_addr;
          dn_wdata_d = '0;
          dn_we_d    = '0;
          rd_pend_d  = 1'b0;
          state_d    = ST_RD_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (dn_written) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (dn_valid) begin
          up_rdata_d = dn_rdata;
          up_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      busy_d      = 1'b1;
      req_addr_d  = up_addr;
      req_wdata_d = up_wdata;
      req_we_d    = up_we;
      if (is_wr) begin
        if (!fifo_full || pop) begin
          push         = 1'b1;
          up_written_d = 1'b1;
        end else begin
          wr_pend_d = 1'b1;
        end
      end else if (!rd_issue) begin
        rd_pend_d = 1'b1;
      end
    end else if (wr_pend_q && pop) begin
      push         = 1'b1;
      push_data    = {req_addr_q, req_wdata_q, req_we_q};
      wr_pend_d    = 1'b0;
      up_written_d = 1'b1;
    end

    if (up_written_d || up_valid_d) busy_d = 1'b0;
  end

  // State, request and output registers; reset aborts any in-flight work.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_we_q     <= '0;
      dn_oe_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_wdata_q   <= '0;
      dn_we_q      <= '0;
      up_written_q <= 1'b0;
      up_valid_q   <= 1'b0;
      up_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      wr_pend_q    <= wr_pend_d;
      rd_pend_q    <= rd_pend_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_we_q     <= req_we_d;
      dn_oe_q      <= dn_oe_d;
      dn_addr_q    <= dn_addr_d;
      dn_wdata_q   <= dn_wdata_d;
      dn_we_q      <= dn_we_d;
      up_written_q <= up_written_d;
      up_valid_q   <= up_valid_d;
      up_rdata_q   <= up_rdata_d;
    end
  end

  assign dn_oe      = dn_oe_q;
  assign dn_addr    = dn_addr_q;
  assign dn_wdata   = dn_wdata_q;
  assign dn_we      = dn_we_q;
  assign up_written = up_written_q;
  assign up_valid   = up_valid_q;
  assign up_rdata   = up_rdata_q;

endmodule

// File: tb/tb_dram_wbuf.sv
// Self-checking bench for dram_wbuf: a downstream DRAM responder with its own
// memory, an in-order scoreboard of expected downstream requests and a
// program-order memory model that predicts read data.
module tb_dram_wbuf;

  localparam int MS    = 27;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [MS-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    we;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_x = 1'b0;
  logic          up_oe = 1'b0;
  logic [MS-1:0] up_addr = '0;
  logic [31:0]   up_wdata = '0;
  logic [3:0]    up_we = '0;
  logic [31:0]   up_rdata;
  logic          up_valid, up_written;
  logic          dn_oe;
  logic [MS-1:0] dn_addr;
  logic [31:0]   dn_wdata;
  logic [3:0]    dn_we;
  logic [31:0]   dn_rdata = '0;
  logic          dn_valid = 1'b0;
  logic          dn_written = 1'b0;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t          exp_wr[$];
  logic [MS-1:0] exp_rd[$];
  logic [31:0]   ref_mem[logic [MS-1:0]];
  logic [31:0]   dram[logic [MS-1:0]];

  int   dn_lat = 1;
  bit   dn_rand_lat = 1'b0;
  bit   dn_stall = 1'b0;
  bit   rsp_pend = 1'b0;
  int   rsp_cnt = 0;
  req_t rsp_req;

  dram_wbuf #(.MEM_SCALE(MS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_x      (rst_x),
    .up_oe      (up_oe),
    .up_addr    (up_addr),
    .up_wdata   (up_wdata),
    .up_we      (up_we),
    .up_rdata   (up_rdata),
    .up_valid   (up_valid),
    .up_written (up_written),
    .dn_oe      (dn_oe),
    .dn_addr    (dn_addr),
    .dn_wdata   (dn_wdata),
    .dn_we      (dn_we),
    .dn_rdata   (dn_rdata),
    .dn_valid   (dn_valid),
    .dn_written (dn_written),
    .level      (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] we);
    for (int b = 0; b < 4; b++) if (we[b]) old[b*8 +: 8] = nw[b*8 +: 8];
    return old;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [MS-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] dram_rd(input logic [MS-1:0] a);
    return dram.exists(a) ? dram[a] : 32'h0;
  endfunction

  // DRAM responder: acts 1 time unit after each edge, answers after dn_lat cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      dn_written = 1'b0;
      dn_valid   = 1'b0;
      if (!rst_x) begin
        rsp_pend = 1'b0;
      end else begin
        if (dn_oe) begin
          checks++;
          if (rsp_pend) begin
            errors++;
            $display("FAIL dn_outstanding: dn_oe with a request still open at cycle %0d", cyc);
          end
        end
        if (rsp_pend) begin
          if (rsp_cnt > 1) rsp_cnt--;
          else if (!dn_stall) begin
            rsp_pend = 1'b0;
            if (rsp_req.we != 4'h0) begin
              dram[rsp_req.addr] = merge(dram_rd(rsp_req.addr), rsp_req.wdata, rsp_req.we);
              dn_written = 1'b1;
            end else begin
              dn_rdata = dram_rd(rsp_req.addr);
              dn_valid = 1'b1;
            end
          end
        end
        if (dn_oe) begin
          rsp_pend = 1'b1;
          rsp_req  = '{dn_addr, dn_wdata, dn_we};
          rsp_cnt  = dn_rand_lat ? int'($urandom_range(1, 4)) : dn_lat;
        end
      end
    end
  end

  // Monitor: level bound, single-cycle dn_oe and in-order downstream scoreboard.
  initial begin
    bit   prev_oe;
    req_t e;
    prev_oe = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst_x) begin
        checks++;
        if (level > LW'(DEPTH)) begin
          errors++;
          $display("FAIL level_bound: level=%0d exceeds %0d", level, DEPTH);
        end
        if (dn_oe) begin
          checks++;
          if (prev_oe) begin
            errors++;
            $display("FAIL dn_oe_pulse: dn_oe high for two cycles at %0d", cyc);
          end
          checks++;
          if (dn_we != 4'h0) begin
            if (exp_wr.size() == 0) begin
              errors++;
              $display("FAIL dn_wr_order: unexpected write addr=%h", dn_addr);
            end else begin
              e = exp_wr.pop_front();
              if ({dn_addr, dn_wdata, dn_we} !== {e.addr, e.wdata, e.we}) begin
                errors++;
                $display("FAIL dn_wr_order: got %h/%h/%h expected %h/%h/%h",
                         dn_addr, dn_wdata, dn_we, e.addr, e.wdata, e.we);
              end
            end
          end else begin
            if (exp_rd.size() == 0) begin
              errors++;
              $display("FAIL dn_rd_order: unexpected read addr=%h", dn_addr);
            end else if (dn_addr !== exp_rd[0]) begin
              errors++;
              $display("FAIL dn_rd_order: got addr %h expected %h", dn_addr, exp_rd[0]);
              void'(exp_rd.pop_front());
            end else begin
              void'(exp_rd.pop_front());
            end
          end
        end
        prev_oe = dn_oe;
      end else begin
        prev_oe = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic issue(input logic [MS-1:0] a, input logic [31:0] d, input logic [3:0] we);
    up_addr  = a;
    up_wdata = d;
    up_we    = we;
    up_oe    = 1'b1;
    if (we != 4'h0) begin
      exp_wr.push_back('{a, d, we});
      ref_mem[a] = merge(ref_rd(a), d, we);
    end else begin
      exp_rd.push_back(a);
    end
    step(1);
    up_oe = 1'b0;
  endtask

  task automatic wait_resp(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (up_written || up_valid) begin
        got = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic drain(input string name, input int bound);
    dn_stall = 1'b0;
    for (int i = 0; i < bound && level != '0; i++) step(1);
    step(3);
    checks++;
    if (level !== '0 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: level=%0d pending_wr=%0d pending_rd=%0d expected all 0",
               name, level, exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_reset();
    rst_x = 1'b0;
    step(3);
    checks++;
    if ({up_valid, up_written, dn_oe, up_rdata, dn_addr, dn_wdata, dn_we, level} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: outputs not all 0 during reset");
    end
    rst_x = 1'b1;
    step(3);
    checks++;
    if ({up_valid, up_written, dn_oe, up_rdata, dn_addr, dn_wdata, dn_we, level} !== '0) begin
      errors++;
      $display("FAIL post_reset_outputs: outputs not all 0 after reset release");
    end
  endtask

  task automatic test_single_write();
    dn_lat = 5;
    issue(27'h100, 32'hDEADBEEF, 4'hF);
    checks++;
    if (up_written !== 1'b1 || dn_oe !== 1'b0) begin
      errors++;
      $display("FAIL wr_accept: up_written=%b dn_oe=%b expected 1/0", up_written, dn_oe);
    end
    step(1);
    checks++;
    if (dn_oe !== 1'b1 || dn_addr !== 27'h100 || dn_wdata !== 32'hDEADBEEF || dn_we !== 4'hF
        || up_written !== 1'b0 || level !== LW'(1)) begin
      errors++;
      $display("FAIL wr_issue: dn_oe=%b addr=%h data=%h we=%h up_written=%b level=%0d",
               dn_oe, dn_addr, dn_wdata, dn_we, up_written, level);
    end
    step(5);
    checks++;
    if (level !== LW'(1) || dn_addr !== 27'h100 || dn_wdata !== 32'hDEADBEEF || dn_we !== 4'hF) begin
      errors++;
      $display("FAIL wr_hold: level=%0d addr=%h data=%h we=%h before completion",
               level, dn_addr, dn_wdata, dn_we);
    end
    step(1);
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL wr_retire: level=%0d expected 0", level);
    end
  endtask

  task automatic test_write_read();
    int wr_done, rd_iss, v_cyc, uv_cyc;
    logic [31:0] rdata;
    bit got;
    dn_lat = 3;
    dram.delete(27'h100);
    wr_done = -1; rd_iss = -1; v_cyc = -1; uv_cyc = -1; rdata = '0;
    issue(27'h100, 32'hDEADBEEF, 4'hF);
    checks++;
    if (up_written !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_accept: up_written=%b expected 1", up_written);
    end
    issue(27'h100, 32'h0, 4'h0);
    for (int i = 0; i < 40; i++) begin
      if (dn_written && wr_done < 0) wr_done = cyc;
      if (dn_oe && dn_we == 4'h0 && rd_iss < 0) rd_iss = cyc;
      if (dn_valid && v_cyc < 0) v_cyc = cyc;
      if (up_valid) begin
        uv_cyc = cyc;
        rdata  = up_rdata;
        break;
      end
      step(1);
    end
    checks++;
    if (uv_cyc < 0 || rd_iss <= wr_done || wr_done < 0 || uv_cyc != v_cyc + 1) begin
      errors++;
      $display("FAIL wr_rd_order: wr_done=%0d rd_issue=%0d dn_valid=%0d up_valid=%0d",
               wr_done, rd_iss, v_cyc, uv_cyc);
    end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_data: up_rdata=%h expected deadbeef", rdata);
    end
    step(2);
    issue(27'h100, 32'h0, 4'h0);
    checks++;
    if (dn_oe !== 1'b1 || dn_addr !== 27'h100 || dn_we !== 4'h0) begin
      errors++;
      $display("FAIL rd_fast_issue: dn_oe=%b addr=%h we=%h one cycle after up_oe",
               dn_oe, dn_addr, dn_we);
    end
    wait_resp(20, got);
    checks++;
    if (!got || up_valid !== 1'b1 || up_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_fast_data: got=%b up_valid=%b up_rdata=%h expected deadbeef",
               got, up_valid, up_rdata);
    end
  endtask

  task automatic test_full();
    bit got;
    dn_lat   = 1;
    dn_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(27'h2000 + MS'(4 * i), $urandom, 4'hF);
      wait_resp(i < 4 ? 4 : 8, got);
      checks++;
      if (got !== (i < 4)) begin
        errors++;
        $display("FAIL full_accept: write %0d up_written seen=%b expected %b", i, got, i < 4);
      end
    end
    checks++;
    if (level !== LW'(DEPTH)) begin
      errors++;
      $display("FAIL full_level: level=%0d expected %0d", level, DEPTH);
    end
    dn_stall = 1'b0;
    step(1);
    dn_stall = 1'b1;
    step(1);
    checks++;
    if (up_written !== 1'b1 || level !== LW'(DEPTH)) begin
      errors++;
      $display("FAIL full_release: up_written=%b level=%0d expected 1/%0d",
               up_written, level, DEPTH);
    end
    drain("full", 100);
  endtask

  task automatic test_wrap();
    bit got;
    dn_lat = 1;
    for (int i = 0; i < 10; i++) begin
      issue(MS'(4 * i), $urandom, 4'hF);
      wait_resp(12, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL wrap_accept: write %0d not acknowledged", i);
      end
    end
    drain("wrap", 200);
  endtask

  task automatic test_reset_mid();
    bit got, bad;
    dn_lat   = 1;
    dn_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(27'h3000 + MS'(4 * i), $urandom, 4'hF);
      wait_resp(4, got);
    end
    step(2);
    checks++;
    if (level !== LW'(3)) begin
      errors++;
      $display("FAIL rst_mid_level: level=%0d expected 3", level);
    end
    rst_x = 1'b0;
    #1;
    checks++;
    if ({up_valid, up_written, dn_oe, up_rdata, dn_addr, dn_wdata, dn_we, level} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: outputs not 0 right after reset assertion");
    end
    exp_wr.delete();
    exp_rd.delete();
    dn_stall = 1'b0;
    step(2);
    rst_x = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (up_written || up_valid || dn_oe || level != '0) bad = 1'b1;
      step(1);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_mid_quiet: activity seen after reset with no new request");
    end
    issue(27'h3100, 32'h0BADF00D, 4'hF);
    checks++;
    if (up_written !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_new: up_written=%b expected 1", up_written);
    end
    drain("rst_mid", 50);
  endtask

  task automatic test_spurious();
    bit got, bad;
    dn_lat   = 1;
    dn_stall = 1'b1;
    issue(27'h3200, 32'h5A5A1234, 4'hF);
    wait_resp(4, got);
    step(3);
    dn_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (up_valid) bad = 1'b1;
    end
    checks++;
    if (bad || level !== LW'(1)) begin
      errors++;
      $display("FAIL spurious_valid: up_valid_seen=%b level=%0d expected 0/1", bad, level);
    end
    drain("spurious", 20);
    issue(27'h3200, 32'h0, 4'h0);
    wait_resp(20, got);
    checks++;
    if (!got || up_rdata !== 32'h5A5A1234) begin
      errors++;
      $display("FAIL spurious_readback: got=%b up_rdata=%h expected 5a5a1234", got, up_rdata);
    end
  endtask

  task automatic test_random();
    bit got;
    logic [MS-1:0] a;
    logic [3:0] we;
    logic [31:0] exp_d;
    dn_rand_lat = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a  = 27'h4000 + MS'(4 * $urandom_range(0, 7));
      we = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom_range(1, 15));
      exp_d = ref_rd(a);
      issue(a, $urandom, we);
      wait_resp(200, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL rand_timeout: op %0d addr=%h we=%h got no response", i, a, we);
      end else if (we != 4'h0) begin
        if (up_written !== 1'b1) begin
          errors++;
          $display("FAIL rand_wr_ack: op %0d up_written=%b expected 1", i, up_written);
        end
      end else if (up_valid !== 1'b1 || up_rdata !== exp_d) begin
        errors++;
        $display("FAIL rand_rd_data: op %0d addr=%h up_rdata=%h expected %h",
                 i, a, up_rdata, exp_d);
      end
      step($urandom_range(0, 2));
    end
    drain("random", 200);
    dn_rand_lat = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_read();
    test_full();
    test_wrap();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_wbuf.md
DRAM_WBUF -- requirements
Module: dram_wbuf

Interface
REQ-001 Parameter MEM_SCALE, default 27: byte-address width of the DRAM space.
REQ-002 Parameter DEPTH, default 4: posted-write FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 rst_x  input  1  reset, asynchronous and active-low.
REQ-005 up_oe  input  1  one-cycle request pulse from the data cache super port.
REQ-006 up_addr  input  MEM_SCALE  request byte address.
REQ-007 up_wdata  input  32  write data.
REQ-008 up_we  input  4  byte enables; nonzero means write, zero means read.
REQ-009 up_rdata  output  32  read data, valid with up_valid.
REQ-010 up_valid  output  1  one-cycle read-completion pulse.
REQ-011 up_written  output  1  one-cycle write-acceptance pulse.
REQ-012 dn_oe  output  1  one-cycle request pulse to the DRAM arbiter data port.
REQ-013 dn_addr, dn_wdata, dn_we  output  MEM_SCALE/32/4  request fields, held stable from dn_oe until completion.
REQ-014 dn_rdata  input  32  arbiter read data.
REQ-015 dn_valid, dn_written  input  1 each  arbiter read/write completion pulses.
REQ-016 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 The upstream side SHALL have at most one request outstanding; up_oe while a request is unanswered is ignored.
REQ-018 A write with FIFO not full SHALL be pushed on the up_oe cycle, with up_written pulsing the next cycle.
REQ-019 A write with FIFO full SHALL be held in a pending register and pushed on the first pop cycle, with up_written the cycle after the push.
REQ-020 At full, a pop and a pending push in the same cycle SHALL both occur and level SHALL stay at DEPTH.
REQ-021 Drain FSM states: IDLE, WR_WAIT, RD_WAIT.
REQ-022 IDLE with FIFO non-empty: issue dn_oe with the head entry, go to WR_WAIT; the head entry is popped on dn_written, then return to IDLE.
REQ-023 A read SHALL be latched and issued downstream only in IDLE with the FIFO empty; writes always drain before it, giving strict program order.
REQ-024 In RD_WAIT, dn_valid SHALL register dn_rdata into up_rdata and pulse up_valid on the next cycle, then return to IDLE.
REQ-025 Minimum latencies: write acceptance 1 cycle; a read with FIFO empty is dn_oe 1 cycle after up_oe plus 1 cycle after dn_valid.
REQ-026 dn_oe SHALL be a single-cycle pulse, at most one downstream request outstanding.
REQ-027 FIFO pointers SHALL be $clog2(DEPTH) bits with natural wrap-around; level SHALL never exceed DEPTH nor underflow.
REQ-028 dn_valid in WR_WAIT or dn_written in RD_WAIT SHALL be ignored.

Reset
REQ-029 Asserting rst_x low SHALL asynchronously clear FIFO, pointers, level, pending/latched requests and FSM to IDLE, aborting any in-flight operation.
REQ-030 During and after reset, all outputs SHALL be 0 until a new request arrives.
REQ-031 No response SHALL be generated for requests lost to reset.

Structure
REQ-032 FSM state encodings and the MEM_SCALE default SHALL live in the shared package; DEPTH remains local.
REQ-033 The FIFO SHALL be one sub-module, wbuf_fifo, with push/pop/full/empty/level; the FSM and pending logic stay in dram_wbuf.

Verification
REQ-034 Write 0xDEADBEEF to 0x100 with we=0xF and a 5-cycle downstream write -> up_written at cycle +1; dn_oe with the same fields at cycle +2; level back to 0 after dn_written.
REQ-035 Write then read 0x100 back-to-back -> dn read issued only after dn_written; up_rdata=0xDEADBEEF and up_valid one cycle after dn_valid.
REQ-036 Five writes with DEPTH=4 and dn_written stalled -> four up_written pulses, fifth withheld; release one dn_written -> fifth accepted, level stays 4.
REQ-037 Ten writes with addresses 0x0..0x24 step 4 and a 1-cycle downstream -> downstream order and data identical to input, pointers wrap twice.
REQ-038 Pull rst_x low mid-WR_WAIT with level=3 -> outputs 0 immediately; no up_written or dn_oe after release until a new up_oe.
REQ-039 Spurious dn_valid in WR_WAIT -> no up_valid, FSM unchanged.
